// File: rtl/led_frame_fetch.sv
`default_nettype none
//==============================================================================
// Module   : led_frame_fetch
// Brief    : Reads 24-bit pixels (two 16-bit SPRAM words each) and presents them
//            to the LED serializer over a valid/ready handshake.
//            Optional macro LED_FETCH_BRIGHTNESS_EN adds a per-byte right-shift
//            brightness control (bright_shift).
// Revision : 1.0 - initial release
//==============================================================================
module led_frame_fetch #(
    parameter int          NUM_LEDS  = 144,
    parameter logic [13:0] BASE_ADDR = 14'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
`ifdef LED_FETCH_BRIGHTNESS_EN
    input  logic [2:0]  bright_shift,
`endif
    output logic        busy,
    output logic [13:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_done
);

    localparam int                 c_IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_LEDS - 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_FETCH_LO = 3'd1;
    localparam logic [2:0] c_FETCH_HI = 3'd2;
    localparam logic [2:0] c_CAP_HI   = 3'd3;
    localparam logic [2:0] c_PRESENT  = 3'd4;
    localparam logic [2:0] c_DONE     = 3'd5;

    logic [2:0]         r_state,    w_state_nxt;
    logic [c_IDX_W-1:0] r_idx,      w_idx_nxt;
    logic [13:0]        r_mem_addr, w_mem_addr_nxt;
    logic [23:0]        r_pix_data, w_pix_data_nxt;
    logic [23:0]        w_pix_raw;
    logic [23:0]        w_pix_present;

    // Word address of the low half of pixel idx; wraps naturally at 2^14.
    function automatic logic [13:0] f_lo_addr(input logic [c_IDX_W-1:0] idx);
        return BASE_ADDR + 14'({idx, 1'b0});
    endfunction

    assign w_pix_raw = {mem_rdata[7:0], r_pix_data[15:0]};

`ifdef LED_FETCH_BRIGHTNESS_EN
    assign w_pix_present = {w_pix_raw[23:16] >> bright_shift,
                            w_pix_raw[15:8]  >> bright_shift,
                            w_pix_raw[7:0]   >> bright_shift};
`else
    assign w_pix_present = w_pix_raw;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_idx      <= '0;
            r_mem_addr <= BASE_ADDR;
            r_pix_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_pix_data <= w_pix_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_mem_addr_nxt = r_mem_addr;
        w_pix_data_nxt = r_pix_data;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt    = c_FETCH_LO;
                    w_idx_nxt      = '0;
                    w_mem_addr_nxt = f_lo_addr('0);
                end
            end
            c_FETCH_LO: begin
                w_state_nxt    = c_FETCH_HI;
                w_mem_addr_nxt = f_lo_addr(r_idx) + 14'd1;
            end
            c_FETCH_HI: begin
                w_state_nxt          = c_CAP_HI;
                w_pix_data_nxt[15:0] = mem_rdata;
            end
            c_CAP_HI: begin
                w_state_nxt    = c_PRESENT;
                w_pix_data_nxt = w_pix_present;
            end
            c_PRESENT: begin
                if (pix_ready) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = c_DONE;
                    end else begin
                        w_state_nxt    = c_FETCH_LO;
                        w_idx_nxt      = r_idx + c_IDX_W'(1);
                        w_mem_addr_nxt = f_lo_addr(r_idx + c_IDX_W'(1));
                    end
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    assign busy       = (r_state != c_IDLE);
    assign pix_valid  = (r_state == c_PRESENT);
    assign frame_done = (r_state == c_DONE);
    assign mem_addr   = r_mem_addr;
    assign pix_data   = r_pix_data;

endmodule
`default_nettype wire

// File: tb/tb_led_frame_fetch.sv
`default_nettype none
//==============================================================================
// Module   : tb_led_frame_fetch
// Brief    : Self-checking bench for led_frame_fetch; four instances with
//            different NUM_LEDS/BASE_ADDR share one SPRAM model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_led_frame_fetch;

    localparam int                 c_NINST = 4;
    localparam logic [3:0][12:0]   c_NL    = {13'd1, 13'd2, 13'd2, 13'd8};
    localparam logic [3:0][13:0]   c_BASE  = {14'h0200, 14'h3FFE, 14'h0000, 14'h0010};

    logic                clk = 1'b0;
    logic                reset;
    logic [c_NINST-1:0]  start;
    logic [c_NINST-1:0]  busy;
    logic [c_NINST-1:0]  pix_valid;
    logic [c_NINST-1:0]  pix_ready;
    logic [c_NINST-1:0]  frame_done;
    logic [13:0]         mem_addr  [c_NINST];
    logic [15:0]         mem_rdata [c_NINST];
    logic [23:0]         pix_data  [c_NINST];
`ifdef LED_FETCH_BRIGHTNESS_EN
    logic [2:0]          bright_shift;
`endif
    logic [15:0]         mem [16384];

    int                  n_checks = 0;
    int                  n_fail   = 0;
    logic [23:0]         got_pix[$];
    logic [13:0]         got_addr[$];

    always #5 clk = ~clk;

    // Synchronous-read SPRAM: data appears one cycle after the address.
    always @(posedge clk) begin
        for (int k = 0; k < c_NINST; k++) mem_rdata[k] <= mem[mem_addr[k]];
    end

    for (genvar g = 0; g < c_NINST; g++) begin : g_dut
        led_frame_fetch #(
            .NUM_LEDS  (int'(c_NL[g])),
            .BASE_ADDR (c_BASE[g])
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .start        (start[g]),
`ifdef LED_FETCH_BRIGHTNESS_EN
            .bright_shift (bright_shift),
`endif
            .busy         (busy[g]),
            .mem_addr     (mem_addr[g]),
            .mem_rdata    (mem_rdata[g]),
            .pix_data     (pix_data[g]),
            .pix_valid    (pix_valid[g]),
            .pix_ready    (pix_ready[g]),
            .frame_done   (frame_done[g])
        );
    end

    // Reference pixel n of instance k: low word, then low byte of the next word.
    function automatic logic [23:0] exp_pix(input int k, input int n);
        int          a;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [23:0] p;
        a  = (int'(c_BASE[k]) + 2 * n) % 16384;
        lo = mem[a];
        hi = mem[(a + 1) % 16384];
        p  = {hi[7:0], lo};
`ifdef LED_FETCH_BRIGHTNESS_EN
        p  = {p[23:16] >> bright_shift, p[15:8] >> bright_shift, p[7:0] >> bright_shift};
`endif
        return p;
    endfunction

    // mode 0: ready always high, 1: random ready, 2: ready low for the first 10 PRESENT cycles
    task automatic run_frame(input int k, input int mode, input int glitch_cyc, input string tag);
        int          fd_cnt;
        int          lat;
        int          cyc;
        int          nl;
        bit          done;
        bit          stalled;
        logic [23:0] hold_pix;
        logic [13:0] hold_addr;
        logic [13:0] ea;
        nl = int'(c_NL[k]);
        fd_cnt = 0; lat = -1; cyc = 0; done = 0; stalled = 0;
        hold_pix = '0; hold_addr = '0;
        got_pix.delete(); got_addr.delete();
        @(posedge clk); #1; start[k] = 1'b1;
        @(posedge clk); #1; start[k] = 1'b0;
        while (!done && cyc < 2000) begin
            cyc++;
            start[k] = (cyc == glitch_cyc);
            if (mode == 0)      pix_ready[k] = 1'b1;
            else if (mode == 1) pix_ready[k] = 1'($urandom_range(0, 1));
            else                pix_ready[k] = (cyc < 4 || cyc >= 14);
            @(negedge clk);
            if (stalled) begin
                n_checks++;
                if (pix_valid[k] !== 1'b1 || pix_data[k] !== hold_pix || mem_addr[k] !== hold_addr) begin
                    n_fail++;
                    $display("FAIL %s stall_hold cyc=%0d: valid=%b data=%h addr=%h, required valid=1 data=%h addr=%h",
                             tag, cyc, pix_valid[k], pix_data[k], mem_addr[k], hold_pix, hold_addr);
                end
            end
            stalled   = (pix_valid[k] === 1'b1) && (pix_ready[k] === 1'b0);
            hold_pix  = pix_data[k];
            hold_addr = mem_addr[k];
            if (busy[k] !== 1'b1) begin
                done = 1;
            end else begin
                if (got_addr.size() == 0 || got_addr[$] !== mem_addr[k]) got_addr.push_back(mem_addr[k]);
                if (pix_valid[k] === 1'b1 && lat < 0) lat = cyc;
                if (pix_valid[k] === 1'b1 && pix_ready[k] === 1'b1) got_pix.push_back(pix_data[k]);
                if (frame_done[k] === 1'b1) fd_cnt++;
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        pix_ready[k] = 1'b0;
        start[k]     = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: busy still %b after %0d cycles, required 0", tag, busy[k], cyc);
        end
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, required 4", tag, lat);
        end
        n_checks++;
        if (fd_cnt != 1) begin
            n_fail++;
            $display("FAIL %s frame_done_count: got %0d, required 1", tag, fd_cnt);
        end
        n_checks++;
        if (got_pix.size() != nl) begin
            n_fail++;
            $display("FAIL %s pixel_count: got %0d, required %0d", tag, got_pix.size(), nl);
        end
        for (int n = 0; n < nl && n < got_pix.size(); n++) begin
            n_checks++;
            if (got_pix[n] !== exp_pix(k, n)) begin
                n_fail++;
                $display("FAIL %s pixel[%0d]: got %h, required %h", tag, n, got_pix[n], exp_pix(k, n));
            end
        end
        n_checks++;
        if (got_addr.size() != 2 * nl) begin
            n_fail++;
            $display("FAIL %s addr_count: got %0d, required %0d", tag, got_addr.size(), 2 * nl);
        end
        for (int i = 0; i < 2 * nl && i < got_addr.size(); i++) begin
            ea = 14'((int'(c_BASE[k]) + i) % 16384);
            n_checks++;
            if (got_addr[i] !== ea) begin
                n_fail++;
                $display("FAIL %s addr[%0d]: got %h, required %h", tag, i, got_addr[i], ea);
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        start     = '0;
        pix_ready = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < c_NINST; k++) begin
            n_checks++;
            if ({busy[k], pix_valid[k], frame_done[k]} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_flags[%0d]: busy/valid/done=%b, required 000", k,
                         {busy[k], pix_valid[k], frame_done[k]});
            end
            n_checks++;
            if (mem_addr[k] !== c_BASE[k] || pix_data[k] !== 24'h0) begin
                n_fail++;
                $display("FAIL reset_regs[%0d]: addr=%h data=%h, required addr=%h data=000000",
                         k, mem_addr[k], pix_data[k], c_BASE[k]);
            end
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        run_frame(1, 0, 0, "basic");
        n_checks++;
        if (got_pix.size() != 2 || got_pix[0] !== 24'h00CEFF || got_pix[1] !== 24'h561234) begin
            n_fail++;
            $display("FAIL basic_const: got %0d pixels first=%h, required 00CEFF then 561234",
                     got_pix.size(), (got_pix.size() > 0) ? got_pix[0] : 24'h0);
        end
    endtask

    task automatic test_stall();
        run_frame(0, 2, 0, "stall");
    endtask

    task automatic test_start_glitch();
        run_frame(1, 0, 6, "start_glitch");
    endtask

    task automatic test_back_to_back();
        int f;
        int hs;
        int fdc;
        f = -1; hs = 0; fdc = 0;
        @(posedge clk); #1;
        start[1]     = 1'b1;
        pix_ready[1] = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (pix_valid[1] === 1'b1 && pix_ready[1] === 1'b1) hs++;
            if (frame_done[1] === 1'b1) begin
                fdc++;
                if (f < 0) f = cyc;
            end
            if (f >= 0 && cyc == f + 1) begin
                n_checks++;
                if (busy[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_idle_gap: busy=%b, required 0", busy[1]);
                end
            end
            if (f >= 0 && cyc == f + 2) begin
                n_checks++;
                if (busy[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_retrigger: busy=%b, required 1", busy[1]);
                end
            end
            if (f >= 0 && cyc > f + 2 && busy[1] === 1'b0) break;
            @(posedge clk); #1;
            if (f >= 0 && cyc >= f + 2) start[1] = 1'b0;
        end
        start[1]     = 1'b0;
        pix_ready[1] = 1'b0;
        n_checks++;
        if (hs != 4 || fdc != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: handshakes=%0d frame_done=%0d, required 4 and 2", hs, fdc);
        end
    endtask

    task automatic test_wrap();
        logic [13:0] exp_w [4];
        exp_w = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        run_frame(2, 1, 0, "wrap");
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            n_checks++;
            if (got_addr[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL wrap_const[%0d]: got %h, required %h", i, got_addr[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_single();
        run_frame(3, 1, 0, "single");
    endtask

    task automatic test_reset_midframe();
        int  hs;
        bit  found;
        bit  any_busy;
        hs = 0; found = 0; any_busy = 0;
        @(posedge clk); #1; start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            pix_ready[0] = (hs < 5);
            @(negedge clk);
            if (pix_valid[0] === 1'b1 && pix_ready[0] === 1'b1) hs++;
            else if (pix_valid[0] === 1'b1 && hs == 5) found = 1;
            if (!found) begin
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (!found || pix_data[0] !== exp_pix(0, 5)) begin
            n_fail++;
            $display("FAIL abort_pixel5: found=%b data=%h, required found=1 data=%h", found, pix_data[0], exp_pix(0, 5));
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({busy[0], pix_valid[0], frame_done[0]} !== 3'b000 || mem_addr[0] !== c_BASE[0] || pix_data[0] !== 24'h0) begin
            n_fail++;
            $display("FAIL abort_async: busy/valid/done=%b addr=%h data=%h, required 000 addr=%h data=000000",
                     {busy[0], pix_valid[0], frame_done[0]}, mem_addr[0], pix_data[0], c_BASE[0]);
        end
        @(negedge clk);
        reset        = 1'b1;
        pix_ready[0] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (busy[0] !== 1'b0) any_busy = 1;
        end
        pix_ready[0] = 1'b0;
        n_checks++;
        if (any_busy) begin
            n_fail++;
            $display("FAIL abort_no_resume: busy seen=1 without start, required 0");
        end
        run_frame(0, 1, 0, "after_abort");
    endtask

`ifdef LED_FETCH_BRIGHTNESS_EN
    task automatic test_brightness();
        mem[0]       = 16'hCEFF;
        mem[1]       = 16'h00FF;
        bright_shift = 3'd1;
        run_frame(1, 0, 0, "bright");
        n_checks++;
        if (got_pix.size() == 0 || got_pix[0] !== 24'h7F677F) begin
            n_fail++;
            $display("FAIL bright_const: got %h, required 7F677F", (got_pix.size() > 0) ? got_pix[0] : 24'h0);
        end
    endtask
`endif

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
`ifdef LED_FETCH_BRIGHTNESS_EN
            bright_shift = 3'($urandom_range(0, 7));
`endif
            run_frame(0, 1, 0, "rand_main");
            run_frame(2, 1, 0, "rand_wrap");
            run_frame(3, 0, 0, "rand_single");
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hCEFF;
        mem[1] = 16'h0000;
        mem[2] = 16'h1234;
        mem[3] = 16'h0056;
`ifdef LED_FETCH_BRIGHTNESS_EN
        bright_shift = 3'd0;
`endif
        test_reset();
        test_basic();
        test_stall();
        test_start_glitch();
        test_back_to_back();
        test_wrap();
        test_single();
        test_reset_midframe();
`ifdef LED_FETCH_BRIGHTNESS_EN
        test_brightness();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_frame_fetch.md
LED_FRAME_FETCH -- requirements
Module: led_frame_fetch

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 144, giving the number of pixels per frame (legal range 1..8191).
REQ-002 SHALL have parameter BASE_ADDR, default 14'd0, giving the SPRAM word address of pixel 0.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge (48 MHz HSOSC domain).
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: frame request, sampled on a rising edge.
REQ-006 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-007 SHALL have port mem_addr, output, 14 bits: registered SPRAM read address.
REQ-008 SHALL have port mem_rdata, input, 16 bits: SPRAM DO, valid one cycle after the address.
REQ-009 SHALL have port pix_data, output, 24 bits: pixel {byte2, byte1, byte0} for the downstream LED serializer.
REQ-010 SHALL have port pix_valid, output, 1 bit: pix_data is valid.
REQ-011 SHALL have port pix_ready, input, 1 bit: serializer accepts the pixel.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel is accepted.

Function
REQ-013 SHALL store pixel n as word BASE_ADDR+2n = pixel[15:0] and word BASE_ADDR+2n+1 = {8'hxx, pixel[23:16]}, with the upper byte ignored.
REQ-014 SHALL implement states IDLE, FETCH_LO, FETCH_HI, CAP_HI, PRESENT, DONE.
REQ-015 SHALL go IDLE->FETCH_LO when start=1, set pixel index to 0, and assert busy from FETCH_LO onward.
REQ-016 SHALL hold mem_addr = BASE_ADDR+2*idx in FETCH_LO and BASE_ADDR+2*idx+1 in FETCH_HI.
REQ-017 SHALL capture mem_rdata into pix_data[15:0] at the end of FETCH_HI and mem_rdata[7:0] into pix_data[23:16] at the end of CAP_HI.
REQ-018 SHALL follow FETCH_LO->FETCH_HI->CAP_HI->PRESENT unconditionally, one cycle each.
REQ-019 SHALL assert pix_valid only in PRESENT and hold pix_data stable until pix_valid&pix_ready.
REQ-020 SHALL, on a PRESENT handshake, go to FETCH_LO with idx+1 if idx<NUM_LEDS-1, else to DONE.
REQ-021 SHALL pulse frame_done for exactly one cycle in DONE, then return to IDLE with busy=0.
REQ-022 SHALL give a latency of 4 cycles from the start sampling edge to pix_valid=1, and a throughput of 1 pixel per 4 cycles with pix_ready held high.
REQ-023 SHALL ignore start when not in IDLE; start held high re-triggers a frame from IDLE on the cycle after DONE.
REQ-024 SHALL hold the index counter at ceil(log2(NUM_LEDS)) bits minimum and compute addresses modulo 2^14.
REQ-025 SHALL, with NUM_LEDS=1, go PRESENT->DONE on the first handshake.
REQ-026 SHALL keep pix_valid at 0 in all states except PRESENT, regardless of pix_ready.

Reset
REQ-027 SHALL, on reset=0 at any time including mid-frame, go to IDLE immediately with idx=0, mem_addr=BASE_ADDR, pix_data=0, pix_valid=0, busy=0, frame_done=0.
REQ-028 SHALL require a fresh start after reset deassertion and not resume the aborted frame.

Configuration
REQ-029 SHALL, when macro LED_FETCH_BRIGHTNESS_EN is defined, add input bright_shift[2:0] and present each byte of pix_data logically right-shifted by bright_shift, sampled at PRESENT entry and stable during PRESENT.
REQ-030 SHALL, when LED_FETCH_BRIGHTNESS_EN is undefined, omit bright_shift and present pix_data exactly as read from memory.

Verification
REQ-031 SHALL cover: NUM_LEDS=2, memory {16'hCEFF,16'h0000,16'h1234,16'h0056}, pix_ready=1 -> pixels 24'h00CEFF then 24'h561234, first pix_valid 4 cycles after start, frame_done pulse once.
REQ-032 SHALL cover: pix_ready held 0 for 10 cycles in PRESENT -> pix_valid stays 1, pix_data unchanged, mem_addr unchanged.
REQ-033 SHALL cover: start pulsed during FETCH_HI of pixel 1 -> ignored, exactly NUM_LEDS handshakes, one frame_done.
REQ-034 SHALL cover: reset=0 asserted in PRESENT of pixel 5 -> pix_valid=0, busy=0, mem_addr=BASE_ADDR without a clock edge; the next start begins at pixel 0.
REQ-035 SHALL cover: BASE_ADDR=14'h3FFE, NUM_LEDS=2 -> addresses 3FFE, 3FFF, 0000, 0001 (wrap).
REQ-036 SHALL cover: LED_FETCH_BRIGHTNESS_EN defined, bright_shift=3'd1, word values 16'hCEFF and 16'h00FF -> pix_data 24'h7F677F.
